// File: rtl/data_ram_resp_pkg.sv
// Shared constants and types for the data RAM responder.
package data_ram_resp_pkg;

  // Default RAM depth (log2, in 32-bit words) and MMIO page selector.
  localparam int unsigned DataMemNumLog2  = 10;
  localparam logic [3:0]  DataRamMmioPage = 4'h1;

  // Data bus width and type.
  localparam int unsigned RegBusWidth = 32;
  typedef logic [RegBusWidth-1:0] reg_bus_t;

  // MMIO word offsets, decoded from addr[3:2].
  localparam logic [1:0] DramCycles  = 2'd0;
  localparam logic [1:0] DramWrites  = 2'd1;
  localparam logic [1:0] DramScratch = 2'd2;
  localparam logic [1:0] DramStatus  = 2'd3;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } dram_state_e;

endpackage

// File: rtl/data_ram_resp_clear_seq.sv
// Post-reset clear sequencer: walks every RAM word once, writing zero, then
// reports ready. A reset at any point restarts the walk from word 0.
module data_ram_resp_clear_seq
  import data_ram_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DataMemNumLog2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  clr_we,
  output logic [DEPTH_LOG2-1:0] clr_addr,
  output logic                  ready
);

  localparam logic [DEPTH_LOG2-1:0] LastIdx = '1;

  dram_state_e           state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_ptr_q, clr_ptr_d;

  // State and clear-pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StInit;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Advance through the array; leave INIT after the last word is cleared.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      StInit: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LastIdx) begin
          state_d = StRun;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  // Outputs depend on state only.
  always_comb begin
    clr_we   = (state_q == StInit);
    clr_addr = clr_ptr_q;
    ready    = (state_q == StRun);
  end

endmodule

// File: rtl/data_ram_resp.sv
// Responder end of the CPU data-memory port. Word-addressed RAM with byte-lane
// writes, zeroed after reset by the clear sequencer. Optional MMIO page
// (cycle counter, write counter, scratch, status) enabled by DATA_RAM_MMIO_EN;
// without it the MMIO page behaves as an out-of-range region.
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DataMemNumLog2,
  parameter logic [3:0]  MMIO_PAGE  = DataRamMmioPage
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  reg_bus_t    data_i,
  output reg_bus_t    data_o,
  output logic        ready_o,
  output logic        err_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic                  clr_we;
  logic [DEPTH_LOG2-1:0] clr_addr;
  logic                  ready;

  data_ram_resp_clear_seq #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  reg_bus_t mem [Depth];

  logic                  is_page;
  logic                  ram_acc;
  logic                  ram_we;
  logic                  mmio_acc;
  logic                  oor;
  logic                  err_set;
  logic                  err_q, err_d;
  logic [DEPTH_LOG2-1:0] index;

  // Byte-offset bits are never used; lanes come from sel_i.
  logic unused_addr;
  assign unused_addr = ^addr_i[1:0];

  // Address decode. All CPU accesses are ignored until the clear completes.
  always_comb begin
    is_page = (addr_i[31:28] == MMIO_PAGE);
    index   = addr_i[DEPTH_LOG2+1:2];
    ram_acc = ce_i & ready & ~is_page & (addr_i[27:DEPTH_LOG2+2] == '0);
    ram_we  = ram_acc & we_i;
`ifdef DATA_RAM_MMIO_EN
    mmio_acc = ce_i & ready & is_page & (addr_i[27:4] == '0);
`else
    mmio_acc = 1'b0;
`endif
    oor     = ce_i & ready & ~ram_acc & ~mmio_acc;
    // Writes while clearing are dropped and flagged.
    err_set = oor | (ce_i & we_i & ~ready);
  end

  // RAM write port: clear sequencer has priority, then CPU byte-lane writes.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_i[b]) begin
          mem[index][8*b +: 8] <= data_i[8*b +: 8];
        end
      end
    end
  end

`ifdef DATA_RAM_MMIO_EN
  reg_bus_t cycles_q, cycles_d;
  reg_bus_t writes_q, writes_d;
  reg_bus_t scratch_q, scratch_d;
  logic     status_clr;

  // MMIO register next-state: free-running RUN counter, accepted-write counter, scratch.
  always_comb begin
    cycles_d   = ready ? cycles_q + 1'b1 : cycles_q;
    writes_d   = ram_we ? writes_q + 1'b1 : writes_q;
    scratch_d  = scratch_q;
    status_clr = 1'b0;
    if (mmio_acc && we_i) begin
      if (addr_i[3:2] == DramScratch) begin
        for (int b = 0; b < 4; b++) begin
          if (sel_i[b]) begin
            scratch_d[8*b +: 8] = data_i[8*b +: 8];
          end
        end
      end
      status_clr = (addr_i[3:2] == DramStatus) & sel_i[0] & data_i[1];
    end
  end

  // MMIO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_q  <= '0;
      writes_q  <= '0;
      scratch_q <= '0;
    end else begin
      cycles_q  <= cycles_d;
      writes_q  <= writes_d;
      scratch_q <= scratch_d;
    end
  end
`endif

  // Sticky error: a new error on the same edge beats a W1C clear.
  always_comb begin
    err_d = err_q;
`ifdef DATA_RAM_MMIO_EN
    if (status_clr) begin
      err_d = 1'b0;
    end
`endif
    if (err_set) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  // Combinational read mux; zero unless a valid read in RUN hits a decoded target.
  always_comb begin
    data_o = '0;
    if (!rst && ce_i && !we_i) begin
      if (ram_acc) begin
        data_o = mem[index];
      end
`ifdef DATA_RAM_MMIO_EN
      else if (mmio_acc) begin
        case (addr_i[3:2])
          DramCycles:  data_o = cycles_q;
          DramWrites:  data_o = writes_q;
          DramScratch: data_o = scratch_q;
          DramStatus:  data_o = {30'b0, err_q, ready};
          default:     data_o = '0;
        endcase
      end
`endif
    end
  end

  assign ready_o = ready;
  assign err_o   = err_q;

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed self-checking bench for data_ram_resp with a 16-word RAM.
module tb_data_ram_resp;

  localparam int unsigned DepthLog2 = 4;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  int checks;
  int errors;

  data_ram_resp #(
    .DEPTH_LOG2(DepthLog2),
    .MMIO_PAGE (4'h1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ce_i    (ce),
    .we_i    (we),
    .addr_i  (addr),
    .sel_i   (sel),
    .data_i  (wdata),
    .data_o  (rdata),
    .ready_o (ready),
    .err_o   (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic idle();
    ce    = 1'b0;
    we    = 1'b0;
    addr  = 32'h0;
    sel   = 4'h0;
    wdata = 32'h0;
  endtask

  // Drive a write now (between negedge and posedge); returns at the next negedge.
  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    ce    = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    sel   = s;
    @(negedge clk);
    idle();
  endtask

  // Drive a read now and let the combinational output settle.
  task automatic cpu_read(input logic [31:0] a);
    ce   = 1'b1;
    we   = 1'b0;
    addr = a;
    sel  = 4'h0;
    #1;
  endtask

  // Pulse reset and wait (bounded) for the clear to finish; returns in the first RUN cycle.
  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ready) break;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_timeout: got ready=%b, expected 1", ready);
    end
  endtask

  task automatic test_reset();
    logic exp_rdy;
    idle();
    @(negedge clk);
    rst = 1'b1;
    cpu_read(32'h4);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready: got %b, expected 0", ready);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL rst_err: got %b, expected 0", err);
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_rdata: got %h, expected 00000000", rdata);
    end
    idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Sample i taken i edges after release: 16 samples at 0, the 17th at 1.
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_rdy = (i == 16);
      checks++;
      if (ready !== exp_rdy) begin
        errors++;
        $display("FAIL init_ready[%0d]: got %b, expected %b", i, ready, exp_rdy);
      end
      if (i == 1) begin
        cpu_read(32'h4);
        checks++;
        if (rdata !== 32'h0) begin
          errors++;
          $display("FAIL init_read: got %h, expected 00000000", rdata);
        end
      end
      if (i == 2) begin
        ce    = 1'b1;
        we    = 1'b1;
        addr  = 32'h4;
        wdata = 32'hCAFEF00D;
        sel   = 4'hF;
      end
      if (i == 3) begin
        idle();
        checks++;
        if (err !== 1'b1) begin
          errors++;
          $display("FAIL init_write_err: got %b, expected 1", err);
        end
      end
    end
    cpu_read(32'h4);
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL init_write_dropped: got %h, expected 00000000", rdata);
    end
    idle();
  endtask

  task automatic test_byte_lanes();
    do_reset();
    cpu_write(32'h8, 32'h11223344, 4'hF);
    cpu_read(32'h8);
    checks++;
    if (rdata !== 32'h11223344) begin
      errors++;
      $display("FAIL raw_next_cycle: got %h, expected 11223344", rdata);
    end
    cpu_write(32'h8, 32'h0000AA00, 4'h2);
    cpu_read(32'h8);
    checks++;
    if (rdata !== 32'h1122AA44) begin
      errors++;
      $display("FAIL lane1_merge: got %h, expected 1122aa44", rdata);
    end
    // sel=0 write is a no-op and not an error; data_o is 0 while we=1.
    ce    = 1'b1;
    we    = 1'b1;
    addr  = 32'h8;
    wdata = 32'hFFFFFFFF;
    sel   = 4'h0;
    #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL read_during_write: got %h, expected 00000000", rdata);
    end
    @(negedge clk);
    idle();
    cpu_read(32'h8);
    checks++;
    if (rdata !== 32'h1122AA44) begin
      errors++;
      $display("FAIL sel0_noop: got %h, expected 1122aa44", rdata);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL sel0_no_err: got %b, expected 0", err);
    end
    ce = 1'b0;
    #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL ce_low_read: got %h, expected 00000000", rdata);
    end
    cpu_write(32'h8, 32'hFFFFFFFF, 4'h9);
    cpu_read(32'h8);
    checks++;
    if (rdata !== 32'hFF22AAFF) begin
      errors++;
      $display("FAIL lane3_lane0: got %h, expected ff22aaff", rdata);
    end
    idle();
  endtask

  task automatic test_out_of_range();
    do_reset();
    cpu_write(32'h0, 32'h00000055, 4'hF);
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL oor_err_before: got %b, expected 0", err);
    end
    cpu_write(32'h40, 32'hDEADBEEF, 4'hF);
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL oor_write_err: got %b, expected 1", err);
    end
    cpu_read(32'h40);
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL oor_read: got %h, expected 00000000", rdata);
    end
    cpu_read(32'h0);
    checks++;
    if (rdata !== 32'h00000055) begin
      errors++;
      $display("FAIL oor_no_alias: got %h, expected 00000055", rdata);
    end
    idle();
  endtask

`ifdef DATA_RAM_MMIO_EN
  task automatic test_mmio();
    do_reset();
    cpu_read(32'h1000_0000);
    checks++;
    if (rdata !== 32'd0) begin
      errors++;
      $display("FAIL cycles_first: got %0d, expected 0", rdata);
    end
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (rdata !== 32'd10) begin
      errors++;
      $display("FAIL cycles_plus10: got %0d, expected 10", rdata);
    end
    cpu_write(32'h0, 32'h1, 4'hF);
    cpu_write(32'h4, 32'h2, 4'hF);
    cpu_write(32'h8, 32'h3, 4'h1);
    cpu_write(32'h40, 32'h4, 4'hF);
    cpu_read(32'h1000_0004);
    checks++;
    if (rdata !== 32'd3) begin
      errors++;
      $display("FAIL writes_count: got %0d, expected 3", rdata);
    end
    cpu_read(32'h1000_000C);
    checks++;
    if (rdata !== 32'h3) begin
      errors++;
      $display("FAIL status_read: got %h, expected 00000003", rdata);
    end
    cpu_write(32'h1000_000C, 32'h2, 4'h1);
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL status_w1c: got %b, expected 0", err);
    end
    cpu_read(32'h1000_000C);
    checks++;
    if (rdata !== 32'h1) begin
      errors++;
      $display("FAIL status_after_clr: got %h, expected 00000001", rdata);
    end
    cpu_write(32'h1000_0008, 32'hA5A5A5A5, 4'hF);
    cpu_write(32'h1000_0008, 32'h00003C00, 4'h2);
    cpu_read(32'h1000_0008);
    checks++;
    if (rdata !== 32'hA5A53CA5) begin
      errors++;
      $display("FAIL scratch_lanes: got %h, expected a5a53ca5", rdata);
    end
    cpu_write(32'h1000_0000, 32'h0, 4'hF);
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL ro_write_no_err: got %b, expected 0", err);
    end
    cpu_read(32'h1000_0010);
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL mmio_oor_read: got %h, expected 00000000", rdata);
    end
    @(negedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL mmio_oor_err: got %b, expected 1", err);
    end
    idle();
  endtask
`else
  task automatic test_no_mmio();
    do_reset();
    cpu_read(32'h1000_0000);
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL nommio_read: got %h, expected 00000000", rdata);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL nommio_err_before: got %b, expected 0", err);
    end
    @(negedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL nommio_err: got %b, expected 1", err);
    end
    idle();
  endtask
`endif

  task automatic test_reset_mid_init();
    logic exp_rdy;
    do_reset();
    cpu_write(32'hC, 32'h12345678, 4'hF);
    cpu_read(32'hC);
    checks++;
    if (rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL mid_pre_data: got %h, expected 12345678", rdata);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_ready: got %b, expected 0", ready);
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_async_rdata: got %h, expected 00000000", rdata);
    end
    idle();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_init_ready: got %b, expected 0", ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_rdy = (i == 16);
      checks++;
      if (ready !== exp_rdy) begin
        errors++;
        $display("FAIL restart_ready[%0d]: got %b, expected %b", i, ready, exp_rdy);
      end
    end
    cpu_read(32'hC);
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_cleared: got %h, expected 00000000", rdata);
    end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle();
    test_reset();
    test_byte_lanes();
    test_out_of_range();
`ifdef DATA_RAM_MMIO_EN
    test_mmio();
`else
    test_no_mmio();
`endif
    test_reset_mid_init();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
